// File: rtl/cap_seq.sv
// Capture sequencer: runs the pre/armed/post/done phases of one acquisition,
// generates the circular write address and arbitrates the SRAM port with host reads.
module cap_seq #(
  parameter int AW = 18
) (
  input  logic          clkin,
  input  logic          nrst,
  input  logic          run,
  input  logic [AW-1:0] pre_cnt,
  input  logic [AW-1:0] post_cnt,
  input  logic          smpl_req,
  input  logic          trig,
  input  logic          rd_req,
  input  logic [7:0]    rd_step,
  output logic [AW-1:0] sram_addr,
  output logic          sram_we,
  output logic          sram_re,
  output logic [AW-1:0] trig_addr,
  output logic [2:0]    state,
  output logic          done,
  output logic          wrapped
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic          run_q;
  logic          rd_pend;
  logic [AW-1:0] waddr;
  logic [AW-1:0] cnt;
  logic [AW-1:0] rd_addr;

  logic          active;
  logic          wr_go;
  logic          rd_go;
  logic [AW-1:0] waddr_inc;
  logic [AW-1:0] waddr_nx;
  logic [AW-1:0] cnt_inc;
  logic [AW-1:0] step_ext;

  // A write is only issued while a capture is live; dropping run discards it.
  assign active    = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign wr_go     = smpl_req & run & active;
  assign rd_go     = (rd_pend | rd_req) & ~wr_go;
  assign waddr_inc = waddr + 1'b1;
  assign waddr_nx  = wr_go ? waddr_inc : waddr;
  assign cnt_inc   = cnt + 1'b1;
  assign step_ext  = {{(AW-8){1'b0}}, rd_step};
  assign done      = (state == S_DONE);

  always_ff @(posedge clkin or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      run_q     <= 1'b0;
      rd_pend   <= 1'b0;
      waddr     <= '0;
      cnt       <= '0;
      rd_addr   <= '0;
      trig_addr <= '0;
      sram_addr <= '0;
      sram_we   <= 1'b0;
      sram_re   <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      run_q   <= run;
      sram_we <= wr_go;
      sram_re <= rd_go;
      if (wr_go)      sram_addr <= waddr;
      else if (rd_go) sram_addr <= rd_addr;

      // Requests arriving while a write holds the port collapse into one read.
      rd_pend <= (rd_pend | rd_req) & wr_go;
      if (rd_go) rd_addr <= rd_addr + step_ext;

      if (wr_go && (&waddr)) wrapped <= 1'b1;

      if (state != S_IDLE && !run) begin
        state <= S_IDLE;
        waddr <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (run && !run_q) begin
              wrapped <= 1'b0;
              cnt     <= '0;
              state   <= (pre_cnt == '0) ? S_ARMED : S_PRE;
            end
          end
          S_PRE: begin
            if (wr_go) begin
              waddr <= waddr_inc;
              if (cnt_inc == pre_cnt) begin
                state <= S_ARMED;
                cnt   <= '0;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          S_ARMED: begin
            waddr <= waddr_nx;
            // A sample coinciding with the trigger is still pre-trigger.
            if (trig) begin
              trig_addr <= waddr_nx;
              cnt       <= '0;
              if (post_cnt == '0) begin
                state   <= S_DONE;
                rd_addr <= waddr_nx - pre_cnt;
              end else begin
                state <= S_POST;
              end
            end
          end
          S_POST: begin
            if (wr_go) begin
              waddr <= waddr_inc;
              cnt   <= cnt_inc;
              if (cnt_inc == post_cnt) begin
                state   <= S_DONE;
                rd_addr <= trig_addr - pre_cnt;
              end
            end
          end
          S_DONE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cap_seq.sv
// Bench for cap_seq: per-cycle comparison against a capture/arbitration model
// expressed as write counts, trigger position and a pending-read flag.
module tb_cap_seq;

  localparam int AW = 12;
  localparam int W  = 2 * AW + 7;

  logic          clkin = 1'b0;
  logic          nrst;
  logic          run, smpl_req, trig, rd_req;
  logic [AW-1:0] pre_cnt, post_cnt;
  logic [7:0]    rd_step;
  logic [AW-1:0] sram_addr, trig_addr;
  logic          sram_we, sram_re, done, wrapped;
  logic [2:0]    state;

  int checks = 0;
  int failures = 0;

  cap_seq #(.AW(AW)) dut (
    .clkin(clkin), .nrst(nrst), .run(run), .pre_cnt(pre_cnt), .post_cnt(post_cnt),
    .smpl_req(smpl_req), .trig(trig), .rd_req(rd_req), .rd_step(rd_step),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_re(sram_re), .trig_addr(trig_addr),
    .state(state), .done(done), .wrapped(wrapped)
  );

  always #5 clkin = ~clkin;

  // Model: phase, write address, writes counted in the current phase, trigger
  // position, read pointer and the pending-read flag.
  logic [2:0]    m_ph;
  logic [AW-1:0] m_wa, m_ta, m_rd, e_addr;
  logic          m_pend, m_wrp, m_rprev, e_we, e_re;
  int            m_cnt;

  task automatic m_reset();
    m_ph = 3'd0; m_wa = '0; m_ta = '0; m_rd = '0; e_addr = '0;
    m_pend = 1'b0; m_wrp = 1'b0; m_rprev = 1'b0; e_we = 1'b0; e_re = 1'b0; m_cnt = 0;
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {sram_we, sram_re, sram_addr, state, trig_addr, done, wrapped};
  endfunction

  function automatic logic [W-1:0] exp_vec();
    return {e_we, e_re, e_addr, m_ph, m_ta, (m_ph == 3'd4), m_wrp};
  endfunction

  // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
  task automatic step(input logic r, input logic s, input logic t, input logic q);
    logic wr, rd;
    run = r; smpl_req = s; trig = t; rd_req = q;
    wr = s && r && (m_ph >= 3'd1) && (m_ph <= 3'd3);
    rd = (m_pend || q) && !wr;
    e_we = wr; e_re = rd;
    if (wr) e_addr = m_wa;
    else if (rd) e_addr = m_rd;
    if (rd) m_rd = m_rd + AW'(rd_step);
    m_pend = (m_pend || q) && wr;
    if (wr && m_wa == '1) m_wrp = 1'b1;
    if (m_ph != 3'd0 && !r) begin
      m_ph = 3'd0; m_wa = '0;
    end else begin
      case (m_ph)
        3'd0: if (r && !m_rprev) begin
          m_wrp = 1'b0; m_cnt = 0; m_ph = (pre_cnt == 0) ? 3'd2 : 3'd1;
        end
        3'd1: if (wr) begin
          m_wa = m_wa + 1'b1; m_cnt++;
          if (m_cnt == int'(pre_cnt)) begin m_ph = 3'd2; m_cnt = 0; end
        end
        3'd2: begin
          if (wr) m_wa = m_wa + 1'b1;
          if (t) begin
            m_ta = m_wa; m_cnt = 0;
            if (post_cnt == 0) begin m_ph = 3'd4; m_rd = m_ta - pre_cnt; end
            else m_ph = 3'd3;
          end
        end
        3'd3: if (wr) begin
          m_wa = m_wa + 1'b1; m_cnt++;
          if (m_cnt == int'(post_cnt)) begin m_ph = 3'd4; m_rd = m_ta - pre_cnt; end
        end
        default: ;
      endcase
    end
    m_rprev = r;
    @(posedge clkin); #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; run = 0; smpl_req = 0; trig = 0; rd_req = 0;
    pre_cnt = '0; post_cnt = '0; rd_step = 8'd0;
    m_reset();
    repeat (2) @(posedge clkin);
    #1;
    checks++; if (state !== 3'd0)    begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (sram_we !== 1'b0)  begin failures++; $display("FAIL rst_we got=%b exp=0", sram_we); end
    checks++; if (sram_re !== 1'b0)  begin failures++; $display("FAIL rst_re got=%b exp=0", sram_re); end
    checks++; if (sram_addr !== '0)  begin failures++; $display("FAIL rst_addr got=%0d exp=0", sram_addr); end
    checks++; if (trig_addr !== '0)  begin failures++; $display("FAIL rst_trig_addr got=%0d exp=0", trig_addr); end
    checks++; if (done !== 1'b0)     begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (wrapped !== 1'b0)  begin failures++; $display("FAIL rst_wrapped got=%b exp=0", wrapped); end
    nrst = 1'b1;
    repeat (3) begin
      step(0, 0, 0, 0);
      checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL rst_idle got=%h exp=%h", dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_basic();
    logic [AW-1:0] wq[$];
    int nw = 0;
    bit tg = 0, s, t;
    bit seen8 = 0;
    pre_cnt = 4; post_cnt = 3; rd_step = 8'd1;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int c = 0; c < 60 && m_ph != 3'd4; c++) begin
      s = 0; t = 0;
      if (nw == 6 && !tg) begin t = 1; tg = 1; end
      else if (c % 2 == 0) s = 1;
      if (s && m_ph >= 3'd1 && m_ph <= 3'd3) nw++;
      step(1, s, t, 0);
      checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL basic_cyc got=%h exp=%h", dut_vec(), exp_vec()); end
      if (sram_we) wq.push_back(sram_addr);
      if (sram_we && sram_addr == 8) begin
        seen8 = 1;
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL basic_done_edge got=%0d exp=4", state); end
      end
    end
    checks++; if (!seen8) begin failures++; $display("FAIL basic_timeout got=no_write_8 exp=write_8"); end
    checks++; if (wq.size() !== 9) begin failures++; $display("FAIL basic_nwrites got=%0d exp=9", wq.size()); end
    foreach (wq[i]) begin
      checks++; if (wq[i] !== AW'(i)) begin failures++; $display("FAIL basic_waddr got=%0d exp=%0d", wq[i], i); end
    end
    checks++; if (trig_addr !== 12'd6) begin failures++; $display("FAIL basic_trig_addr got=%0d exp=6", trig_addr); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", done); end
    step(1, 0, 0, 1);
    checks++; if (!(sram_re === 1'b1 && sram_addr === 12'd2)) begin
      failures++; $display("FAIL basic_rd_addr got=re%b/%0d exp=re1/2", sram_re, sram_addr);
    end
    step(1, 1, 0, 0);
    checks++; if (sram_we !== 1'b0) begin failures++; $display("FAIL basic_done_nowrite got=%b exp=0", sram_we); end
  endtask

  task automatic test_zero_counts();
    pre_cnt = 0; post_cnt = 0; rd_step = 8'd5;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL zero_armed got=%0d exp=2", state); end
    step(1, 1, 0, 0);
    checks++; if (!(sram_we === 1'b1 && sram_addr === '0)) begin failures++; $display("FAIL zero_write got=we%b/%0d exp=we1/0", sram_we, sram_addr); end
    step(1, 0, 1, 0);
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL zero_done got=%0d exp=4", state); end
    checks++; if (trig_addr !== 12'd1) begin failures++; $display("FAIL zero_trig_addr got=%0d exp=1", trig_addr); end
    repeat (3) begin
      step(1, 1, 0, 0);
      checks++; if (sram_we !== 1'b0) begin failures++; $display("FAIL zero_nowrite got=%b exp=0", sram_we); end
    end
    step(1, 0, 0, 1);
    checks++; if (sram_addr !== 12'd1) begin failures++; $display("FAIL zero_rd_addr got=%0d exp=1", sram_addr); end
  endtask

  task automatic test_random();
    bit s, t, q;
    for (int it = 0; it < 8; it++) begin
      pre_cnt  = AW'($urandom_range(0, 12));
      post_cnt = AW'($urandom_range(0, 12));
      rd_step  = 8'($urandom_range(0, 255));
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int c = 0; c < 250; c++) begin
        s = ($urandom % 3) != 0;
        t = ($urandom % 6) == 0;
        q = ($urandom % 5) == 0;
        step(1, s, t, q);
        checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL rand_cyc it=%0d c=%0d got=%h exp=%h", it, c, dut_vec(), exp_vec()); end
        if (m_ph == 3'd4 && ($urandom % 8) == 0) break;
      end
    end
  endtask

  task automatic test_collision();
    logic [AW-1:0] base;
    int nrd = 0;
    pre_cnt = 2; post_cnt = 50; rd_step = 8'd3;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL coll_armed got=%0d exp=2", state); end
    base = m_rd;
    step(1, 1, 0, 1);
    checks++; if (!(sram_we === 1'b1 && sram_re === 1'b0)) begin failures++; $display("FAIL coll_we_first got=we%b re%b exp=we1 re0", sram_we, sram_re); end
    step(1, 0, 0, 0);
    checks++; if (!(sram_re === 1'b1 && sram_we === 1'b0 && sram_addr === base)) begin
      failures++; $display("FAIL coll_re_next got=re%b/%0d exp=re1/%0d", sram_re, sram_addr, base);
    end
    step(1, 0, 0, 1);
    checks++; if (!(sram_re === 1'b1 && sram_addr === base + 12'd3)) begin
      failures++; $display("FAIL coll_step got=re%b/%0d exp=re1/%0d", sram_re, sram_addr, base + 12'd3);
    end
    step(1, 1, 0, 1);
    if (sram_re) nrd++;
    step(1, 1, 0, 1);
    if (sram_re) nrd++;
    repeat (3) begin
      step(1, 0, 0, 0);
      if (sram_re) nrd++;
      checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL coll_cyc got=%h exp=%h", dut_vec(), exp_vec()); end
    end
    checks++; if (nrd != 1) begin failures++; $display("FAIL coll_merge got=%0d exp=1", nrd); end
  endtask

  task automatic test_wrap();
    int nw = 0;
    bit tg = 0, t;
    pre_cnt = 2; post_cnt = 3; rd_step = 8'd1;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int c = 0; c < 4400 && m_ph != 3'd4; c++) begin
      t = 0;
      if (nw == 4096 + 50 && !tg) begin t = 1; tg = 1; end
      if (m_ph >= 3'd1 && m_ph <= 3'd3) nw++;
      step(1, 1, t, 0);
      checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL wrap_cyc c=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
    end
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL wrap_timeout got=%0d exp=4", state); end
    checks++; if (wrapped !== 1'b1) begin failures++; $display("FAIL wrap_flag got=%b exp=1", wrapped); end
    checks++; if (trig_addr !== 12'd51) begin failures++; $display("FAIL wrap_trig_addr got=%0d exp=51", trig_addr); end
    step(1, 0, 0, 1);
    checks++; if (!(sram_re === 1'b1 && sram_addr === 12'd49)) begin
      failures++; $display("FAIL wrap_rd_addr got=re%b/%0d exp=re1/49", sram_re, sram_addr);
    end
  endtask

  task automatic test_abort();
    pre_cnt = 2; post_cnt = 5; rd_step = 8'd1;
    step(0, 0, 0, 0);
    checks++; if (!(state === 3'd0 && wrapped === 1'b1)) begin failures++; $display("FAIL abort_idle_sticky got=st%0d/w%b exp=st0/w1", state, wrapped); end
    step(1, 0, 0, 0);
    checks++; if (wrapped !== 1'b0) begin failures++; $display("FAIL abort_restart_wrapped got=%b exp=0", wrapped); end
    step(1, 1, 0, 0);
    checks++; if (!(sram_we === 1'b1 && sram_addr === '0)) begin failures++; $display("FAIL abort_restart_waddr got=we%b/%0d exp=we1/0", sram_we, sram_addr); end
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL abort_post got=%0d exp=3", state); end
    step(0, 1, 0, 0);
    checks++; if (!(state === 3'd0 && sram_we === 1'b0)) begin failures++; $display("FAIL abort_idle got=st%0d we%b exp=st0 we0", state, sram_we); end
    repeat (3) begin
      step(0, 1, 0, 0);
      checks++; if ({sram_we, done} !== 2'b00) begin failures++; $display("FAIL abort_quiet got=%b exp=00", {sram_we, done}); end
    end
    checks++; if (trig_addr !== 12'd2) begin failures++; $display("FAIL abort_trig_keep got=%0d exp=2", trig_addr); end
  endtask

  task automatic test_reset_mid();
    pre_cnt = 1; post_cnt = 20; rd_step = 8'd1;
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    checks++; if (!(state === 3'd3 && sram_we === 1'b1)) begin failures++; $display("FAIL rmid_pre got=st%0d we%b exp=st3 we1", state, sram_we); end
    #3 nrst = 1'b0;
    #1;
    checks++; if ({state, sram_we, sram_re, sram_addr, trig_addr, done, wrapped} !== '0) begin
      failures++; $display("FAIL rmid_async got=%h exp=0", {state, sram_we, sram_re, sram_addr, trig_addr, done, wrapped});
    end
    run = 0; smpl_req = 0;
    @(posedge clkin); #1;
    nrst = 1'b1;
    m_reset();
    step(0, 0, 0, 0);
    checks++; if (dut_vec() !== exp_vec()) begin failures++; $display("FAIL rmid_after got=%h exp=%h", dut_vec(), exp_vec()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_counts();
    test_random();
    test_collision();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cap_seq.md
# cap_seq

Capture sequencer and SRAM port arbiter for the scope/logic-analyser acquisition path. It runs the pre-trigger, armed, post-trigger and done phases of one capture. It generates the circular 18-bit write address and records the trigger position. It also shares the single SRAM port between decimated sample writes and host (SPI) reads, computing the read-out start address when capture completes.

## Interface
- AW, 18, SRAM address width; all address arithmetic is modulo 2^AW
- clkin  in  1  system clock, all logic on rising edge
- nrst  in  1  asynchronous, active-low reset
- run  in  1  capture enable level; rising edge starts a capture, low aborts to IDLE
- pre_cnt  in  AW  number of samples written before the trigger is accepted
- post_cnt  in  AW  number of samples written after the trigger
- smpl_req  in  1  one-cycle pulse per decimated sample (write request)
- trig  in  1  trigger event, sampled only in ARMED
- rd_req  in  1  one-cycle host read request
- rd_step  in  8  read address increment, zero-extended to AW
- sram_addr  out  AW  registered SRAM address
- sram_we  out  1  registered write strobe (one cycle per access)
- sram_re  out  1  registered read strobe (one cycle per access)
- trig_addr  out  AW  address of first post-trigger sample
- state  out  3  IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4
- done  out  1  high in DONE
- wrapped  out  1  sticky; write address wrapped during the current capture

## Operation
- Reset values:
  - state=IDLE, and all counters and addresses 0.
  - sram_we, sram_re, done and wrapped are 0.
  - sram_addr and trig_addr are 0.
  - The read-pending flag is 0.
- IDLE:
  - waddr is held at 0.
  - On a run rising edge (run=1, previous run=0):
    - clear wrapped and the sample counter;
    - go to PRE, or directly to ARMED if pre_cnt==0.
- PRE:
  - Each issued write increments waddr and the counter.
  - When the counter reaches pre_cnt, go to ARMED and clear the counter.
  - trig is ignored in PRE.
- ARMED:
  - Writes continue circularly.
  - trig=1 latches trig_addr = waddr after this cycle's increment, then goes to POST, or to DONE if post_cnt==0.
  - trig coinciding with smpl_req: that sample is pre-trigger.
- POST:
  - Each issued write increments the counter.
  - The write that makes the counter equal post_cnt is the last one; the next state is DONE.
- DONE:
  - No writes; smpl_req is ignored; done=1.
  - On DONE entry, rd_addr = trig_addr − pre_cnt (mod 2^AW).
- run=0 in any non-IDLE state:
  - go to IDLE next cycle and drop any unissued write;
  - rd_addr and trig_addr are preserved.
- Wrap:
  - waddr wraps from 2^AW−1 to 0.
  - Any wrap in PRE, ARMED or POST sets wrapped, which stays set until the next capture start.
- Arbitration:
  - A write always wins.
  - rd_req sets the pending flag.
  - The pending read issues on the first cycle in which no write issues, then clears.
  - rd_req while a read is already pending merges into that one read.
  - After each read issues, rd_addr += rd_step.
  - Reads are allowed in every state.
  - Reads starve while writes issue every cycle; this is accepted behaviour.

## Timing
- smpl_req in cycle N (accepted state) gives sram_we=1 in cycle N+1, with sram_addr=waddr. waddr increments at the end of N.
- rd_req in cycle N with no write scheduled for N+1 gives sram_re=1 in cycle N+1, with sram_addr=rd_addr.
- sram_we and sram_re are never high together. Both are single-cycle.
- State transitions take effect on the clock edge after the qualifying write-issue decision, so the PRE→ARMED edge coincides with sram_we of the last pre-trigger sample.
- nrst assertion mid-capture forces the reset values asynchronously. Any in-flight strobe is cut immediately.

## Test plan
- Basic capture, pre_cnt=4, post_cnt=3:
  - stimulus: smpl_req every 2 cycles, trig after the 6th write;
  - response: writes to addresses 0..8, trig_addr=6, DONE after write to address 8, rd_addr=2.
- Zero counts, pre_cnt=0, post_cnt=0:
  - stimulus: run rising edge, then trig;
  - response: state IDLE→ARMED immediately, then DONE on trig cycle+1, trig_addr = current waddr, no writes after trig.
- Wrap, AW=18, pre_cnt=2, trigger delayed past 262144 writes:
  - response: wrapped=1, trig_addr correct modulo 2^18, rd_addr = trig_addr−2 mod 2^18.
- Collision:
  - stimulus: smpl_req and rd_req in the same cycle, rd_step=3;
  - response: sram_we first, sram_re the following cycle at rd_addr, then rd_addr+3.
  - A second rd_req while pending produces exactly one read.
- Abort:
  - stimulus: run dropped in POST;
  - response: IDLE next cycle, no further sram_we, done=0.
  - Restart clears wrapped and waddr=0.
- Reset mid-POST:
  - stimulus: nrst pulse;
  - response: all outputs at reset values immediately, state=0.
